max7219_spi_slave: RTL and testbench

MAX7219_SPI_SLAVE -- requirements
Module: max7219_spi_slave

---
 rtl/max7219_spi_slave.sv | 235 +++++++++++++++++++++++
 tb/tb_max7219_spi_slave.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_spi_slave.sv
// -----------------------------------------------------------------------------
// max7219_spi_slave
//
// Behavioural model of the MAX7219 serial interface and register file. It is
// implemented as a fully synchronous slave in the clk_clk domain.
//
// The SPI pins are asynchronous to clk_clk. Each pin is synchronised, and
// edges are found by comparing the synchronised value with a one-cycle-delayed
// copy. A 16-bit frame shifts in MSB first while spi_ss0 is low. The rising
// edge of spi_ss0 latches the frame into the register file.
//
// Ports
//   clk_clk       in   system clock, rising edge
//   reset_reset   in   synchronous active-high reset
//   spi_clk       in   SPI clock (MAX7219 CLK), async
//   spi_mosi      in   SPI data in (MAX7219 DIN), async
//   spi_ss0       in   frame select, active low (MAX7219 LOAD/CS), async
//   spi_miso      out  cascade data out (MAX7219 DOUT), 16-bit delayed DIN
//   rd_addr       in   digit register index 0..7
//   rd_data       out  digit[rd_addr], one cycle of latency
//   decode_mode   out  decode-mode register
//   intensity     out  intensity register
//   scan_limit    out  scan-limit register
//   shutdown_n    out  shutdown register (0 = shutdown)
//   display_test  out  display-test register
//   frame_valid   out  one-cycle pulse per accepted 16+ bit frame
//   frame_addr    out  address of last accepted frame
//   frame_data    out  data of last accepted frame
//   frame_err     out  one-cycle pulse when a frame closes with < 16 bits
// -----------------------------------------------------------------------------
module max7219_spi_slave #(
    parameter int SYNC_STAGES = 2   // legal range 2..3
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    input  logic       spi_ss0,
    output logic       spi_miso,
    input  logic [2:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [7:0] decode_mode,
    output logic [3:0] intensity,
    output logic [2:0] scan_limit,
    output logic       shutdown_n,
    output logic       display_test,
    output logic       frame_valid,
    output logic [3:0] frame_addr,
    output logic [7:0] frame_data,
    output logic       frame_err
);

    // Synchronisers and edge-detect history
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic                   sclk_prev_q;
    logic                   ss_prev_q;

    // Synchronised views and decoded edges
    logic sclk_s;
    logic mosi_s;
    logic ss_s;
    logic sclk_rise_s;
    logic sclk_fall_s;
    logic ss_rise_s;
    logic ss_fall_s;
    logic shift_s;
    logic miso_load_s;

    // Frame datapath and register file
    logic [15:0] shreg_q,        shreg_d;
    logic [4:0]  cnt_q,          cnt_d;
    logic        miso_q,         miso_d;
    logic [7:0]  digit_q [8];
    logic [7:0]  digit_d [8];
    logic [7:0]  decode_q,       decode_d;
    logic [3:0]  intensity_q,    intensity_d;
    logic [2:0]  scan_q,         scan_d;
    logic        shutdown_n_q,   shutdown_n_d;
    logic        test_q,         test_d;
    logic [7:0]  rd_data_q,      rd_data_d;
    logic        fvalid_q,       fvalid_d;
    logic        ferr_q,         ferr_d;
    logic [3:0]  faddr_q,        faddr_d;
    logic [7:0]  fdata_q,        fdata_d;

    // Frame field decode
    logic [3:0]  frm_addr_s;
    logic [7:0]  frm_data_s;
    logic [3:0]  digit_idx_s;

    // Synchroniser chains plus one history register per edge-detected signal
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss0};
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
        end
    end

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign ss_s        = ss_sync_q[SYNC_STAGES-1];
    assign sclk_rise_s = sclk_s & ~sclk_prev_q;
    assign sclk_fall_s = ~sclk_s & sclk_prev_q;
    assign ss_rise_s   = ss_s & ~ss_prev_q;
    assign ss_fall_s   = ~ss_s & ss_prev_q;
    // A clock edge that coincides with the frame latch is dropped.
    assign shift_s     = sclk_rise_s & ~ss_s & ~ss_rise_s;
    assign miso_load_s = sclk_fall_s & ~ss_s & ~ss_rise_s;

    assign frm_addr_s  = shreg_q[11:8];
    assign frm_data_s  = shreg_q[7:0];
    assign digit_idx_s = frm_addr_s - 4'd1;

    // Next-state logic: shift register, bit counter, DOUT and frame latch
    always_comb begin
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        miso_d       = miso_q;
        digit_d      = digit_q;
        decode_d     = decode_q;
        intensity_d  = intensity_q;
        scan_d       = scan_q;
        shutdown_n_d = shutdown_n_q;
        test_d       = test_q;
        faddr_d      = faddr_q;
        fdata_d      = fdata_q;
        fvalid_d     = 1'b0;
        ferr_d       = 1'b0;
        rd_data_d    = digit_q[rd_addr];

        if (ss_fall_s) begin
            cnt_d = 5'd0;
        end else if (shift_s) begin
            shreg_d = {shreg_q[14:0], mosi_s};
            if (cnt_q != 5'd16) begin
                cnt_d = cnt_q + 5'd1;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q;
        end

        // DOUT changes on the falling edge so a downstream device samples it
        // cleanly on the next rising edge.
        if (miso_load_s) begin
            miso_d = shreg_q[15];
        end else begin
            miso_d = miso_q;
        end

        if (ss_rise_s) begin
            if (cnt_q == 5'd16) begin
                fvalid_d = 1'b1;
                faddr_d  = frm_addr_s;
                fdata_d  = frm_data_s;
                case (frm_addr_s)
                    4'h1, 4'h2, 4'h3, 4'h4,
                    4'h5, 4'h6, 4'h7, 4'h8: digit_d[digit_idx_s[2:0]] = frm_data_s;
                    4'h9:    decode_d     = frm_data_s;
                    4'hA:    intensity_d  = frm_data_s[3:0];
                    4'hB:    scan_d       = frm_data_s[2:0];
                    4'hC:    shutdown_n_d = frm_data_s[0];
                    4'hF:    test_d       = frm_data_s[0];
                    default: ; // 0x0 no-op, 0xD/0xE change nothing
                endcase
            end else begin
                ferr_d = 1'b1;
            end
        end else begin
            fvalid_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            shreg_q      <= 16'h0000;
            cnt_q        <= 5'd0;
            miso_q       <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                digit_q[i] <= 8'h00;
            end
            decode_q     <= 8'h00;
            intensity_q  <= 4'h0;
            scan_q       <= 3'd0;
            shutdown_n_q <= 1'b0;
            test_q       <= 1'b0;
            rd_data_q    <= 8'h00;
            fvalid_q     <= 1'b0;
            ferr_q       <= 1'b0;
            faddr_q      <= 4'h0;
            fdata_q      <= 8'h00;
        end else begin
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            miso_q       <= miso_d;
            digit_q      <= digit_d;
            decode_q     <= decode_d;
            intensity_q  <= intensity_d;
            scan_q       <= scan_d;
            shutdown_n_q <= shutdown_n_d;
            test_q       <= test_d;
            rd_data_q    <= rd_data_d;
            fvalid_q     <= fvalid_d;
            ferr_q       <= ferr_d;
            faddr_q      <= faddr_d;
            fdata_q      <= fdata_d;
        end
    end

    assign spi_miso     = miso_q;
    assign rd_data      = rd_data_q;
    assign decode_mode  = decode_q;
    assign intensity    = intensity_q;
    assign scan_limit   = scan_q;
    assign shutdown_n   = shutdown_n_q;
    assign display_test = test_q;
    assign frame_valid  = fvalid_q;
    assign frame_err    = ferr_q;
    assign frame_addr   = faddr_q;
    assign frame_data   = fdata_q;

endmodule

// File: tb/tb_max7219_spi_slave.sv
// Self-checking bench for max7219_spi_slave. Expected frame outcomes are
// queued as each frame is driven and compared when the DUT reports the frame.
module tb_max7219_spi_slave;

    typedef struct packed {
        logic       err;
        logic [3:0] addr;
        logic [7:0] data;
    } exp_t;

    logic       clk_clk = 1'b0;
    logic       reset_reset = 1'b1;
    logic       spi_clk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_ss0 = 1'b1;
    logic       spi_miso;
    logic [2:0] rd_addr = 3'd0;
    logic [7:0] rd_data;
    logic [7:0] decode_mode;
    logic [3:0] intensity;
    logic [2:0] scan_limit;
    logic       shutdown_n;
    logic       display_test;
    logic       frame_valid;
    logic [3:0] frame_addr;
    logic [7:0] frame_data;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    exp_t e;
    int nvalid;
    int nerr;
    logic [3:0]  got_addr;
    logic [7:0]  got_data;
    logic [31:0] miso_trace;

    max7219_spi_slave #(.SYNC_STAGES(2)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_ss0(spi_ss0),
        .spi_miso(spi_miso), .rd_addr(rd_addr), .rd_data(rd_data),
        .decode_mode(decode_mode), .intensity(intensity),
        .scan_limit(scan_limit), .shutdown_n(shutdown_n),
        .display_test(display_test), .frame_valid(frame_valid),
        .frame_addr(frame_addr), .frame_data(frame_data),
        .frame_err(frame_err)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic idle(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    task automatic ss_low();
        @(negedge clk_clk);
        miso_trace = 32'h0;
        spi_ss0 = 1'b0;
        idle(4);
    endtask

    // Shifts n bits of v MSB first; spi_miso is sampled just before each rise.
    task automatic shift_bits(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            spi_mosi = v[n-1-i];
            idle(4);
            miso_trace = {miso_trace[30:0], spi_miso};
            spi_clk = 1'b1;
            idle(4);
            spi_clk = 1'b0;
        end
        idle(4);
    endtask

    // Watches a bounded window after ss0 rises and records what the DUT reported.
    task automatic collect_frame();
        nvalid = 0;
        nerr = 0;
        got_addr = 4'h0;
        got_data = 8'h00;
        repeat (12) begin
            @(negedge clk_clk);
            if (frame_valid) begin
                nvalid++;
                got_addr = frame_addr;
                got_data = frame_data;
            end
            if (frame_err) nerr++;
        end
    endtask

    task automatic run_frame(input logic [31:0] v, input int n, input exp_t ex);
        exp_q.push_back(ex);
        ss_low();
        shift_bits(v, n);
        spi_ss0 = 1'b1;
        collect_frame();
    endtask

    task automatic read_digit(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk_clk);
        rd_addr = a;
        @(negedge clk_clk);
        d = rd_data;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        reset_reset = 1'b1;
        idle(3);
        checks++;
        if ({decode_mode, intensity, scan_limit, shutdown_n, display_test} !== 17'h0) begin
            errors++;
            $display("FAIL reset_ctrl: got %h expected 0", {decode_mode, intensity, scan_limit, shutdown_n, display_test});
        end
        checks++;
        if ({frame_valid, frame_err, frame_addr, frame_data, spi_miso, rd_data} !== 23'h0) begin
            errors++;
            $display("FAIL reset_frame: got %h expected 0", {frame_valid, frame_err, frame_addr, frame_data, spi_miso, rd_data});
        end
        reset_reset = 1'b0;
        idle(2);
        for (int i = 0; i < 8; i++) begin
            read_digit(3'(i), d);
            checks++;
            if (d !== 8'h00) begin
                errors++;
                $display("FAIL reset_digit%0d: got %h expected 00", i, d);
            end
        end
    endtask

    task automatic test_digit_write();
        logic [7:0] d;
        run_frame(32'h0355, 16, '{1'b0, 4'h3, 8'h55});
        e = exp_q.pop_front();
        checks++;
        if (nvalid !== 1 || nerr !== 0 || got_addr !== e.addr || got_data !== e.data) begin
            errors++;
            $display("FAIL digit_frame: got v=%0d e=%0d %h/%h expected v=1 e=0 %h/%h", nvalid, nerr, got_addr, got_data, e.addr, e.data);
        end
        read_digit(3'd2, d);
        checks++;
        if (d !== 8'h55) begin
            errors++;
            $display("FAIL digit_read: got %h expected 55", d);
        end
    endtask

    task automatic test_controls();
        logic [15:0] frames [4];
        frames[0] = 16'h0A07; frames[1] = 16'h0B05; frames[2] = 16'h0C01; frames[3] = 16'h0F01;
        for (int i = 0; i < 4; i++) begin
            run_frame({16'h0, frames[i]}, 16, '{1'b0, frames[i][11:8], frames[i][7:0]});
            e = exp_q.pop_front();
            checks++;
            if (nvalid !== 1 || nerr !== 0 || got_addr !== e.addr || got_data !== e.data) begin
                errors++;
                $display("FAIL ctrl_frame%0d: got v=%0d e=%0d %h/%h expected v=1 e=0 %h/%h", i, nvalid, nerr, got_addr, got_data, e.addr, e.data);
            end
        end
        checks++;
        if (intensity !== 4'h7 || scan_limit !== 3'd5 || shutdown_n !== 1'b1 || display_test !== 1'b1) begin
            errors++;
            $display("FAIL ctrl_regs: got %h %0d %b %b expected 7 5 1 1", intensity, scan_limit, shutdown_n, display_test);
        end
    endtask

    task automatic test_short_frame();
        logic [7:0] d;
        run_frame(32'h0A3, 12, '{1'b1, 4'h0, 8'h00});
        e = exp_q.pop_front();
        checks++;
        if (nvalid !== 0 || nerr !== 1 || e.err !== 1'b1) begin
            errors++;
            $display("FAIL short_frame: got v=%0d e=%0d expected v=0 e=1", nvalid, nerr);
        end
        checks++;
        if (intensity !== 4'h7 || scan_limit !== 3'd5 || frame_addr !== 4'hF || frame_data !== 8'h01) begin
            errors++;
            $display("FAIL short_regs: got %h %0d %h %h expected 7 5 f 01", intensity, scan_limit, frame_addr, frame_data);
        end
        read_digit(3'd2, d);
        checks++;
        if (d !== 8'h55) begin
            errors++;
            $display("FAIL short_digit: got %h expected 55", d);
        end
    endtask

    task automatic test_long_frame();
        logic [7:0] d;
        run_frame(32'h0111_0822, 32, '{1'b0, 4'h8, 8'h22});
        e = exp_q.pop_front();
        checks++;
        if (nvalid !== 1 || nerr !== 0 || got_addr !== e.addr || got_data !== e.data) begin
            errors++;
            $display("FAIL long_frame: got v=%0d e=%0d %h/%h expected v=1 e=0 %h/%h", nvalid, nerr, got_addr, got_data, e.addr, e.data);
        end
        checks++;
        if (miso_trace[15:0] !== 16'h0111) begin
            errors++;
            $display("FAIL long_miso: got %h expected 0111", miso_trace[15:0]);
        end
        read_digit(3'd7, d);
        checks++;
        if (d !== 8'h22) begin
            errors++;
            $display("FAIL long_digit7: got %h expected 22", d);
        end
        read_digit(3'd0, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL long_digit0: got %h expected 00", d);
        end
    endtask

    task automatic test_decode();
        run_frame(32'h09AB, 16, '{1'b0, 4'h9, 8'hAB});
        e = exp_q.pop_front();
        checks++;
        if (nvalid !== 1 || decode_mode !== e.data) begin
            errors++;
            $display("FAIL decode_set: got v=%0d %h expected v=1 %h", nvalid, decode_mode, e.data);
        end
        run_frame(32'hF900, 16, '{1'b0, 4'h9, 8'h00});
        e = exp_q.pop_front();
        checks++;
        if (nvalid !== 1 || nerr !== 0 || got_addr !== e.addr || got_data !== e.data || decode_mode !== 8'h00) begin
            errors++;
            $display("FAIL decode_clear: got v=%0d %h/%h dm=%h expected v=1 %h/%h dm=00", nvalid, got_addr, got_data, decode_mode, e.addr, e.data);
        end
    endtask

    task automatic test_noop();
        run_frame(32'h0D12, 16, '{1'b0, 4'hD, 8'h12});
        e = exp_q.pop_front();
        checks++;
        if (nvalid !== 1 || got_addr !== e.addr || got_data !== e.data) begin
            errors++;
            $display("FAIL noop_frame: got v=%0d %h/%h expected v=1 %h/%h", nvalid, got_addr, got_data, e.addr, e.data);
        end
        checks++;
        if (intensity !== 4'h7 || scan_limit !== 3'd5 || shutdown_n !== 1'b1 || display_test !== 1'b1 || decode_mode !== 8'h00) begin
            errors++;
            $display("FAIL noop_regs: got %h %0d %b %b %h expected 7 5 1 1 00", intensity, scan_limit, shutdown_n, display_test, decode_mode);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        exp_q.push_back('{1'b1, 4'h0, 8'h00});
        ss_low();
        shift_bits(32'hA5, 8);
        reset_reset = 1'b1;
        idle(2);
        reset_reset = 1'b0;
        idle(1);
        checks++;
        if ({decode_mode, intensity, scan_limit, shutdown_n, display_test, frame_addr, frame_data, spi_miso} !== 30'h0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h expected 0", {decode_mode, intensity, scan_limit, shutdown_n, display_test, frame_addr, frame_data, spi_miso});
        end
        idle(3);
        spi_ss0 = 1'b1;
        collect_frame();
        e = exp_q.pop_front();
        checks++;
        if (nvalid !== 0 || nerr !== 1 || e.err !== 1'b1) begin
            errors++;
            $display("FAIL midreset_err: got v=%0d e=%0d expected v=0 e=1", nvalid, nerr);
        end
        read_digit(3'd2, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL midreset_digit: got %h expected 00", d);
        end
    endtask

    initial begin
        test_reset();
        test_digit_write();
        test_controls();
        test_short_frame();
        test_long_frame();
        test_decode();
        test_noop();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
